// File: rtl/sat_alarm_monitor_pkg.sv
// Shared types and helpers for the saturation-alarm monitor.
package sat_alarm_monitor_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_REPORT = 1'b1
   } mon_state_e;

   // Increment that holds at the all-ones value of a w-bit counter.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input int unsigned w
   );
      logic [31:0] m;
      m = 32'hFFFF_FFFF >> (32 - w);
      return (v >= m) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sat_window_counter.sv
// Per-window sample index and event accumulator.
module sat_window_counter
   import sat_alarm_monitor_pkg::*;
#(
   parameter int WINDOW = 1024,
   parameter int CNT_W  = 11
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic             i_sat_alarm,
   output logic             o_last,
   output logic [CNT_W-1:0] o_sum
);

   localparam int IDX_W = $clog2(WINDOW);

   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_acc;

   assign o_sum  = r_acc + {{(CNT_W-1){1'b0}}, i_sat_alarm};
   assign o_last = i_valid & (r_idx == IDX_W'(WINDOW - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
         r_acc <= '0;
      end else if (i_valid) begin
         if (o_last) begin
            r_idx <= '0;
            r_acc <= '0;
         end else begin
            r_idx <= r_idx + 1'b1;
            r_acc <= o_sum;
         end
      end
   end

endmodule

// File: rtl/sat_alarm_monitor.sv
// Saturation-alarm monitor: windowed counts, peak, lifetime total, irq.
module sat_alarm_monitor
   import sat_alarm_monitor_pkg::*;
#(
   parameter  int WINDOW    = 1024,
   parameter  int THRESHOLD = 16,
   parameter  int TOTAL_W   = 16,
   localparam int CNT_W     = $clog2(WINDOW + 1)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               valid_i,
   input  logic               sat_alarm_i,
   input  logic               clear_i,
   input  logic               irq_ack_i,
   output logic [CNT_W-1:0]   window_cnt_o,
   output logic               window_done_o,
   output logic [CNT_W-1:0]   peak_cnt_o,
   output logic [TOTAL_W-1:0] total_o,
   output logic               sticky_o,
   output logic               irq_o
);

   mon_state_e         r_state;
   mon_state_e         w_state_nxt;
   logic               w_done;
   logic               w_last;
   logic               w_hit;
   logic [CNT_W-1:0]   w_sum;
   logic [CNT_W-1:0]   r_win;
   logic [CNT_W-1:0]   r_peak;
   logic [TOTAL_W-1:0] r_total;
   logic               r_sticky;
   logic               r_irq;

   assign w_hit = valid_i & sat_alarm_i;

   sat_window_counter #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) u_win (
      .i_clk       (clk_i),
      .i_rst_n     (rst_n_i),
      .i_clear     (clear_i),
      .i_valid     (valid_i),
      .i_sat_alarm (sat_alarm_i),
      .o_last      (w_last),
      .o_sum       (w_sum)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= ST_RUN;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      unique case (r_state)
         ST_RUN: begin
            if (w_last) w_state_nxt = ST_REPORT;
         end
         ST_REPORT: begin
            w_done      = 1'b1;
            w_state_nxt = ST_RUN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
      if (clear_i) w_state_nxt = ST_RUN;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_win    <= '0;
         r_peak   <= '0;
         r_total  <= '0;
         r_sticky <= 1'b0;
         r_irq    <= 1'b0;
      end else if (clear_i) begin
         r_win    <= '0;
         r_peak   <= '0;
         r_total  <= '0;
         r_sticky <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_last) r_win <= w_sum;
         if (w_hit) begin
            r_total  <= TOTAL_W'(sat_inc(32'(r_total), TOTAL_W));
            r_sticky <= 1'b1;
         end
         if (w_done && (r_win > r_peak)) r_peak <= r_win;
         // A threshold hit in REPORT outranks a coincident acknowledge.
         if (w_done && (r_win >= CNT_W'(THRESHOLD))) r_irq <= 1'b1;
         else if (irq_ack_i)                          r_irq <= 1'b0;
      end
   end

   assign window_cnt_o  = r_win;
   assign window_done_o = w_done;
   assign peak_cnt_o    = r_peak;
   assign total_o       = r_total;
   assign sticky_o      = r_sticky;
   assign irq_o         = r_irq;

endmodule

// File: tb/tb_sat_alarm_monitor.sv
// Randomized and directed bench for sat_alarm_monitor (WINDOW=8, THRESHOLD=3).
module tb_sat_alarm_monitor;

   localparam int WIN  = 8;
   localparam int TH   = 3;
   localparam int TW   = 4;
   localparam int CW   = 4;
   localparam int TMAX = 15;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          valid_i;
   logic          sat_alarm_i;
   logic          clear_i;
   logic          irq_ack_i;
   logic [CW-1:0] window_cnt_o;
   logic          window_done_o;
   logic [CW-1:0] peak_cnt_o;
   logic [TW-1:0] total_o;
   logic          sticky_o;
   logic          irq_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_n, m_ev, m_win, m_peak, m_total;
   bit m_rep, m_sticky, m_irq;

   sat_alarm_monitor #(
      .WINDOW    (WIN),
      .THRESHOLD (TH),
      .TOTAL_W   (TW)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .valid_i       (valid_i),
      .sat_alarm_i   (sat_alarm_i),
      .clear_i       (clear_i),
      .irq_ack_i     (irq_ack_i),
      .window_cnt_o  (window_cnt_o),
      .window_done_o (window_done_o),
      .peak_cnt_o    (peak_cnt_o),
      .total_o       (total_o),
      .sticky_o      (sticky_o),
      .irq_o         (irq_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_n = 0; m_ev = 0; m_win = 0; m_peak = 0; m_total = 0;
      m_rep = 0; m_sticky = 0; m_irq = 0;
   endtask

   // One clock: drive inputs, take the edge, advance the model, settle.
   task automatic cyc(input bit v, input bit a, input bit c, input bit k);
      valid_i = v; sat_alarm_i = a; clear_i = c; irq_ack_i = k;
      @(posedge clk_i);
      if (c) begin
         model_reset();
      end else begin
         if (m_rep) begin
            m_peak = (m_win > m_peak) ? m_win : m_peak;
            if (m_win >= TH) m_irq = 1;
            else if (k)      m_irq = 0;
         end else if (k) begin
            m_irq = 0;
         end
         m_rep = 0;
         if (v) begin
            if (a) begin
               m_total = (m_total < TMAX) ? m_total + 1 : TMAX;
               m_sticky = 1;
               m_ev++;
            end
            m_n++;
            if (m_n == WIN) begin
               m_win = m_ev; m_rep = 1; m_n = 0; m_ev = 0;
            end
         end
      end
      #1;
      valid_i = 0; sat_alarm_i = 0; clear_i = 0; irq_ack_i = 0;
   endtask

   task automatic test_reset();
      rst_n_i = 0; valid_i = 0; sat_alarm_i = 0; clear_i = 0; irq_ack_i = 0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #2;
      checks++;
      if ({window_cnt_o, window_done_o, peak_cnt_o, total_o, sticky_o, irq_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got cnt=%0d done=%0d peak=%0d tot=%0d st=%0d irq=%0d exp all 0",
                  window_cnt_o, window_done_o, peak_cnt_o, total_o, sticky_o, irq_o);
      end
      @(negedge clk_i);
      rst_n_i = 1;
   endtask

   task automatic test_basic();
      for (int i = 0; i < WIN; i++) cyc(1, (i == 1 || i == 4), 0, 0);
      checks++;
      if (window_done_o !== 1'b1) begin
         errors++; $display("FAIL basic_done got %0d exp 1", window_done_o);
      end
      checks++;
      if (window_cnt_o !== 4'd2) begin
         errors++; $display("FAIL basic_cnt got %0d exp 2", window_cnt_o);
      end
      checks++;
      if (total_o !== 4'd2 || sticky_o !== 1'b1) begin
         errors++; $display("FAIL basic_total got %0d/%0d exp 2/1", total_o, sticky_o);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (window_done_o !== 1'b0 || peak_cnt_o !== 4'd2 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_after got done=%0d peak=%0d irq=%0d exp 0/2/0",
                  window_done_o, peak_cnt_o, irq_o);
      end
   endtask

   task automatic test_gapped();
      for (int i = 0; i < WIN; i++) begin
         cyc(0, 1, 0, 0);
         cyc(0, 1, 0, 0);
         cyc(1, (i == 0 || i == 3 || i == 6), 0, 0);
      end
      checks++;
      if (window_done_o !== 1'b1 || window_cnt_o !== 4'd3 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL gapped_report got done=%0d cnt=%0d irq=%0d exp 1/3/0",
                  window_done_o, window_cnt_o, irq_o);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (irq_o !== 1'b1 || peak_cnt_o !== 4'd3 || total_o !== 4'd5) begin
         errors++;
         $display("FAIL gapped_irq got irq=%0d peak=%0d tot=%0d exp 1/3/5",
                  irq_o, peak_cnt_o, total_o);
      end
   endtask

   task automatic test_ack_collision();
      cyc(0, 0, 0, 1);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++; $display("FAIL ack_lone1 got %0d exp 0", irq_o);
      end
      for (int i = 0; i < WIN; i++) cyc(1, (i < 4), 0, 0);
      checks++;
      if (window_done_o !== 1'b1 || window_cnt_o !== 4'd4) begin
         errors++;
         $display("FAIL ack_report got done=%0d cnt=%0d exp 1/4", window_done_o, window_cnt_o);
      end
      cyc(0, 0, 0, 1);
      checks++;
      if (irq_o !== 1'b1 || peak_cnt_o !== 4'd4) begin
         errors++; $display("FAIL ack_collide got irq=%0d peak=%0d exp 1/4", irq_o, peak_cnt_o);
      end
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 1);
      checks++;
      if (irq_o !== 1'b0) begin
         errors++; $display("FAIL ack_lone2 got %0d exp 0", irq_o);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1, 0, 0);
         checks++;
         if (window_done_o !== (i == 7 || i == 15)) begin
            errors++; $display("FAIL b2b_done i=%0d got %0d", i, window_done_o);
         end
         if (i == 7 || i == 15) begin
            checks++;
            if (window_cnt_o !== 4'd8) begin
               errors++; $display("FAIL b2b_cnt i=%0d got %0d exp 8", i, window_cnt_o);
            end
         end
      end
      checks++;
      if (total_o !== 4'd15 || peak_cnt_o !== 4'd8) begin
         errors++; $display("FAIL b2b_total got tot=%0d peak=%0d exp 15/8", total_o, peak_cnt_o);
      end
   endtask

   task automatic test_clear();
      cyc(0, 0, 1, 0);
      for (int i = 0; i < WIN - 1; i++) cyc(1, 1, 0, 0);
      cyc(1, 1, 1, 0);
      checks++;
      if ({window_cnt_o, window_done_o, peak_cnt_o, total_o, sticky_o, irq_o} !== '0) begin
         errors++;
         $display("FAIL clear_outputs got cnt=%0d done=%0d peak=%0d tot=%0d st=%0d irq=%0d exp 0",
                  window_cnt_o, window_done_o, peak_cnt_o, total_o, sticky_o, irq_o);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (window_done_o !== 1'b0) begin
         errors++; $display("FAIL clear_nodone got %0d exp 0", window_done_o);
      end
      for (int i = 0; i < WIN; i++) begin
         cyc(1, (i == 2 || i == 5), 0, 0);
         if (i < WIN - 1) begin
            checks++;
            if (window_done_o !== 1'b0) begin
               errors++; $display("FAIL clear_early i=%0d got %0d exp 0", i, window_done_o);
            end
         end
      end
      checks++;
      if (window_done_o !== 1'b1 || window_cnt_o !== 4'd2) begin
         errors++;
         $display("FAIL clear_next got done=%0d cnt=%0d exp 1/2", window_done_o, window_cnt_o);
      end
   endtask

   task automatic test_async_reset();
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
      #2;
      rst_n_i = 0;
      #1;
      model_reset();
      checks++;
      if ({window_cnt_o, window_done_o, peak_cnt_o, total_o, sticky_o, irq_o} !== '0) begin
         errors++;
         $display("FAIL async_rst got cnt=%0d peak=%0d tot=%0d st=%0d exp 0",
                  window_cnt_o, peak_cnt_o, total_o, sticky_o);
      end
      @(negedge clk_i);
      rst_n_i = 1;
      for (int i = 0; i < WIN; i++) begin
         cyc(1, (i == 0), 0, 0);
         checks++;
         if (window_done_o !== (i == WIN - 1)) begin
            errors++; $display("FAIL async_win i=%0d got %0d", i, window_done_o);
         end
      end
      checks++;
      if (window_cnt_o !== 4'd1) begin
         errors++; $display("FAIL async_cnt got %0d exp 1", window_cnt_o);
      end
   endtask

   task automatic test_random();
      bit v, a, c, k;
      for (int i = 0; i < 600; i++) begin
         v = ($urandom % 4) != 0;
         a = ($urandom % 3) == 0;
         c = ($urandom % 80) == 0;
         k = ($urandom % 7) == 0;
         cyc(v, a, c, k);
         checks++;
         if (window_done_o !== m_rep || window_cnt_o !== CW'(m_win)) begin
            errors++;
            $display("FAIL rnd_win i=%0d got done=%0d cnt=%0d exp %0d/%0d",
                     i, window_done_o, window_cnt_o, m_rep, m_win);
         end
         checks++;
         if (peak_cnt_o !== CW'(m_peak) || total_o !== TW'(m_total)) begin
            errors++;
            $display("FAIL rnd_stat i=%0d got peak=%0d tot=%0d exp %0d/%0d",
                     i, peak_cnt_o, total_o, m_peak, m_total);
         end
         checks++;
         if (sticky_o !== m_sticky || irq_o !== m_irq) begin
            errors++;
            $display("FAIL rnd_flags i=%0d got st=%0d irq=%0d exp %0d/%0d",
                     i, sticky_o, irq_o, m_sticky, m_irq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_ack_collision();
      test_back_to_back();
      test_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
